// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the MEM-stage request port and a
// byte-addressed data memory. Stores queue in a FIFO and drain in order when
// the memory port is free; loads take the port with priority and only stall
// when they touch a word that a buffered store also touches.
// Optional feature macro: SB_FWD_EN -- a word load whose youngest overlapping
// entry is a word store to the identical address is served from the buffer.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [2:0]       req_funct3,
    output logic             req_ready,
    output logic             load_valid,
    output logic [31:0]      load_data,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_rw,
    output logic [2:0]       mem_funct3,
    input  logic [31:0]      mem_rdata,
    output logic             sb_empty,
    output logic [CNT_W-1:0] sb_count
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [2:0] F3_WORD = 3'b010;

    // Word index of the last byte touched by an access of the given size code.
    function automatic logic [29:0] last_word(input logic [31:0] addr, input logic [2:0] funct3);
        logic [2:0] span;
        case (funct3[1:0])
            2'b00:   span = 3'd0;
            2'b01:   span = 3'd1;
            default: span = 3'd3;
        endcase
        return addr[31:2] + ((({1'b0, addr[1:0]} + span) > 3'd3) ? 30'd1 : 30'd0);
    endfunction

    // NOTE: the entry array has no reset; validity is carried by head/count,
    // so clearing the payload would only cost flops and buy nothing.
    logic [31:0]      ent_addr   [DEPTH];
    logic [31:0]      ent_wdata  [DEPTH];
    logic [2:0]       ent_funct3 [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             load_q;      // a load was accepted last cycle

    logic             full;
    logic             conflict;
    logic             fwd_hit;
    logic             store_acc;
    logic             load_acc;
    logic             load_issue;
    logic             drain;
    logic [29:0]      req_first;
    logic [29:0]      req_last;

`ifdef SB_FWD_EN
    logic [PTR_W-1:0] young;       // youngest conflicting entry
    logic             fwd_q;
    logic [31:0]      fwd_data_q;
`endif

    assign req_first = req_addr[31:2];
    assign req_last  = last_word(req_addr, req_funct3);
    assign full      = (count == CNT_W'(DEPTH));

    // Scan valid entries oldest-first; any shared word index is a conflict,
    // and the last hit found is the youngest overlapping store.
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic [29:0]      ent_first;
        logic [29:0]      ent_last;
        // NOTE: every variable gets a default before any branch so no latch
        // can be inferred from a path that leaves it unassigned.
        conflict  = 1'b0;
        idx       = '0;
        ent_first = '0;
        ent_last  = '0;
`ifdef SB_FWD_EN
        young     = head;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx       = head + PTR_W'(i);
            ent_first = ent_addr[idx][31:2];
            ent_last  = last_word(ent_addr[idx], ent_funct3[idx]);
            if ((CNT_W'(i) < count) &&
                ((ent_first == req_first) || (ent_first == req_last) ||
                 (ent_last  == req_first) || (ent_last  == req_last))) begin
                conflict = 1'b1;
`ifdef SB_FWD_EN
                young    = idx;
`endif
            end
        end
    end

`ifdef SB_FWD_EN
    assign fwd_hit = conflict && (req_funct3 == F3_WORD) &&
                     (ent_funct3[young] == F3_WORD) && (ent_addr[young] == req_addr);
`else
    assign fwd_hit = 1'b0;
`endif

    // A drain in this cycle does not make room for this cycle's store.
    assign req_ready  = req_we ? !full : (!conflict || fwd_hit);
    assign store_acc  = req_valid && req_we && !full;
    assign load_acc   = req_valid && !req_we && req_ready;
    assign load_issue = load_acc && !fwd_hit;
    // The cycle after a load belongs to its read data, so no write may issue.
    assign drain      = !load_acc && !load_q && (count != '0);

    // Memory port mux: load read, head-entry write, or a quiet idle pattern.
    always_comb begin
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = F3_WORD;
        if (load_issue) begin
            mem_addr   = req_addr;
            mem_funct3 = req_funct3;
        end else if (drain) begin
            mem_rw     = 1'b1;
            mem_addr   = ent_addr[head];
            mem_wdata  = ent_wdata[head];
            mem_funct3 = ent_funct3[head];
        end
    end

    // Capture an accepted store into the tail slot.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // flop samples pre-edge values regardless of block ordering.
        if (store_acc) begin
            ent_addr[tail]   <= req_addr;
            ent_wdata[tail]  <= req_wdata;
            ent_funct3[tail] <= req_funct3;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (store_acc) tail <= tail + PTR_W'(1);
            if (drain)     head <= head + PTR_W'(1);
            case ({store_acc, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Remember last cycle's load so its result can be presented now.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) load_q <= 1'b0;
        else          load_q <= load_acc;
    end

`ifdef SB_FWD_EN
    // Hold forwarded store data for presentation in the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= load_acc && fwd_hit;
            fwd_data_q <= fwd_hit ? ent_wdata[young] : '0;
        end
    end

    assign load_data = !load_q ? '0 : (fwd_q ? fwd_data_q : mem_rdata);
`else
    assign load_data = load_q ? mem_rdata : '0;
`endif

    assign load_valid = load_q;
    assign sb_empty   = (count == '0);
    assign sb_count   = count;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and randomized checks of store_buffer against a
// reference model that keeps an in-order store queue and an architectural
// byte memory where stores land at acceptance.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             reset_n;
    logic             req_valid;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [2:0]       req_funct3;
    logic             req_ready;
    logic             load_valid;
    logic [31:0]      load_data;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_rw;
    logic [2:0]       mem_funct3;
    logic [31:0]      mem_rdata;
    logic             sb_empty;
    logic [CNT_W-1:0] sb_count;

    store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3), .req_ready(req_ready),
        .load_valid(load_valid), .load_data(load_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
        .sb_empty(sb_empty), .sb_count(sb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
    } st_t;

    logic [7:0]  phys [0:1023];   // memory the DUT actually writes
    logic [7:0]  arch [0:1023];   // program-order view of memory
    st_t         q [$];
    bit          prev_load;
    logic [31:0] prev_val;
    int          n_tests;
    int          n_fail;

    bit               obs_ready, obs_rw, obs_lv, obs_empty;
    logic [31:0]      obs_addr, obs_wdata, obs_ld;
    logic [CNT_W-1:0] obs_count;

    function automatic logic [31:0] size_of(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return 32'd1;
            2'b01:   return 32'd2;
            default: return 32'd4;
        endcase
    endfunction

    function automatic logic [31:0] fmt(input logic [31:0] le, input logic [2:0] f);
        case (f)
            3'b000:  return {{24{le[7]}}, le[7:0]};
            3'b001:  return {{16{le[15]}}, le[15:0]};
            3'b100:  return {24'd0, le[7:0]};
            3'b101:  return {16'd0, le[15:0]};
            default: return le;
        endcase
    endfunction

    function automatic logic [31:0] arch_word(input logic [31:0] a);
        logic [9:0] ix;
        ix = a[9:0];
        return {arch[ix + 10'd3], arch[ix + 10'd2], arch[ix + 10'd1], arch[ix]};
    endfunction

    function automatic logic [31:0] phys_word(input logic [31:0] a);
        logic [9:0] ix;
        ix = a[9:0];
        return {phys[ix + 10'd3], phys[ix + 10'd2], phys[ix + 10'd1], phys[ix]};
    endfunction

    // Two accesses clash when their word-index intervals intersect.
    function automatic bit overlaps(input logic [31:0] a1, input logic [2:0] f1,
                                    input logic [31:0] a2, input logic [2:0] f2);
        logic [31:0] lo1, hi1, lo2, hi2;
        lo1 = a1 >> 2;
        hi1 = (a1 + size_of(f1) - 32'd1) >> 2;
        lo2 = a2 >> 2;
        hi2 = (a2 + size_of(f2) - 32'd1) >> 2;
        return (lo1 <= hi2) && (lo2 <= hi1);
    endfunction

`ifdef SB_FWD_EN
    function automatic bit can_fwd(input logic [31:0] a, input logic [2:0] f);
        for (int i = q.size() - 1; i >= 0; i--)
            if (overlaps(q[i].addr, q[i].f3, a, f))
                return (f == 3'b010) && (q[i].f3 == 3'b010) && (q[i].addr == a);
        return 1'b0;
    endfunction
`endif

    function automatic logic [2:0] pick_f3(input int k);
        case (k)
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b010;
            3:       return 3'b100;
            default: return 3'b101;
        endcase
    endfunction

    // Memory: registered read of whatever the port shows while mem_rw=0.
    always @(posedge clk) begin
        if (mem_rw) begin
            for (int k = 0; k < 32'(size_of(mem_funct3)); k++)
                phys[mem_addr[9:0] + 10'(k)] <= mem_wdata[8*k +: 8];
        end else begin
            mem_rdata <= fmt(phys_word(mem_addr), mem_funct3);
        end
    end

    // One clock of stimulus; DUT outputs are compared to the model mid-cycle.
    task automatic cycle(input bit v, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f, output bit acc);
        bit          conf, fwd, e_ready, lacc, drn, e_rw, chk_wd;
        logic [31:0] e_addr, e_wdata;
        logic [2:0]  e_f3;
        st_t         ent;
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_funct3 = f;
        @(negedge clk);
        conf = 1'b0;
        foreach (q[i]) if (overlaps(q[i].addr, q[i].f3, a, f)) conf = 1'b1;
        fwd = 1'b0;
`ifdef SB_FWD_EN
        if (!we && conf) fwd = can_fwd(a, f);
`endif
        e_ready = we ? (q.size() < DEPTH) : (!conf || fwd);
        acc  = v && e_ready;
        lacc = acc && !we;
        drn  = !lacc && !prev_load && (q.size() > 0);
        e_rw = 1'b0; e_addr = '0; e_wdata = '0; e_f3 = 3'b010; chk_wd = 1'b1;
        if (lacc && !fwd) begin
            e_addr = a; e_f3 = f; chk_wd = 1'b0;
        end else if (drn) begin
            e_rw = 1'b1; e_addr = q[0].addr; e_wdata = q[0].data; e_f3 = q[0].f3;
        end
        obs_ready = req_ready; obs_rw = mem_rw; obs_addr = mem_addr; obs_wdata = mem_wdata;
        obs_lv = load_valid; obs_ld = load_data; obs_count = sb_count; obs_empty = sb_empty;
        if (v) begin
            n_tests++;
            if (req_ready !== e_ready) begin n_fail++; $display("FAIL req_ready t=%0t got %0b exp %0b", $time, req_ready, e_ready); end
        end
        n_tests++;
        if (mem_rw !== e_rw) begin n_fail++; $display("FAIL mem_rw t=%0t got %0b exp %0b", $time, mem_rw, e_rw); end
        n_tests++;
        if (mem_addr !== e_addr) begin n_fail++; $display("FAIL mem_addr t=%0t got %h exp %h", $time, mem_addr, e_addr); end
        n_tests++;
        if (mem_funct3 !== e_f3) begin n_fail++; $display("FAIL mem_funct3 t=%0t got %b exp %b", $time, mem_funct3, e_f3); end
        if (chk_wd) begin
            n_tests++;
            if (mem_wdata !== e_wdata) begin n_fail++; $display("FAIL mem_wdata t=%0t got %h exp %h", $time, mem_wdata, e_wdata); end
        end
        n_tests++;
        if (load_valid !== prev_load) begin n_fail++; $display("FAIL load_valid t=%0t got %0b exp %0b", $time, load_valid, prev_load); end
        if (prev_load) begin
            n_tests++;
            if (load_data !== prev_val) begin n_fail++; $display("FAIL load_data t=%0t got %h exp %h", $time, load_data, prev_val); end
        end
        n_tests++;
        if (sb_count !== CNT_W'(q.size())) begin n_fail++; $display("FAIL sb_count t=%0t got %0d exp %0d", $time, sb_count, q.size()); end
        n_tests++;
        if (sb_empty !== (q.size() == 0)) begin n_fail++; $display("FAIL sb_empty t=%0t got %0b exp %0b", $time, sb_empty, q.size() == 0); end
        @(posedge clk);
        if (drn) void'(q.pop_front());
        if (acc && we) begin
            ent.addr = a; ent.data = d; ent.f3 = f;
            q.push_back(ent);
            for (int k = 0; k < 32'(size_of(f)); k++) arch[a[9:0] + 10'(k)] = d[8*k +: 8];
        end
        if (lacc) prev_val = fmt(arch_word(a), f);
        prev_load = lacc;
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b0, 1'b0, 32'd0, 32'd0, 3'b010, acc);
    endtask

    // Hold one request until accepted, with a bounded wait.
    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, output int stalls);
        bit acc;
        acc = 1'b0;
        stalls = 0;
        while (!acc && stalls < 20) begin
            cycle(1'b1, we, a, d, f, acc);
            if (!acc) stalls++;
        end
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL issue_timeout t=%0t addr %h got no accept exp accept within 20", $time, a);
        end
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        reset_n = 1'b0;
        #2;
        n_tests++;
        if (sb_count !== '0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", sb_count); end
        n_tests++;
        if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %0b exp 1", sb_empty); end
        n_tests++;
        if (load_valid !== 1'b0) begin n_fail++; $display("FAIL rst_load_valid got %0b exp 0", load_valid); end
        n_tests++;
        if (load_data !== 32'd0) begin n_fail++; $display("FAIL rst_load_data got %h exp 0", load_data); end
        n_tests++;
        if (mem_rw !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rw got %0b exp 0", mem_rw); end
        @(posedge clk);
        #1;
        n_tests++;
        if (mem_rw !== 1'b0) begin n_fail++; $display("FAIL rst_hold_mem_rw got %0b exp 0", mem_rw); end
        reset_n = 1'b1;
        q.delete();
        prev_load = 1'b0;
        for (int i = 0; i < 1024; i++) arch[i] = phys[i];
    endtask

    task automatic test_reset();
        do_reset();
        idle(2);
        n_tests++;
        if (obs_lv !== 1'b0) begin n_fail++; $display("FAIL reset_no_pulse got %0b exp 0", obs_lv); end
    endtask

    task automatic test_single_store();
        int st;
        idle(2);
        issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, st);
        idle(1);
        n_tests++;
        if (obs_rw !== 1'b1 || obs_addr !== 32'h10 || obs_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_drain got rw=%0b %h %h exp 1 00000010 deadbeef", obs_rw, obs_addr, obs_wdata);
        end
        idle(1);
        n_tests++;
        if (obs_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got %0b exp 1", obs_empty); end
    endtask

    task automatic test_full();
        bit acc;
        idle(6);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b1, 32'h180 + 32'(k * 8), $urandom, 3'b010, acc);
            if (k > 0) begin
                n_tests++;
                if (obs_lv !== 1'b1) begin n_fail++; $display("FAIL full_load_pulse k=%0d got %0b exp 1", k, obs_lv); end
            end
            if (k == 4) begin
                n_tests++;
                if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b exp 0", obs_ready); end
                n_tests++;
                if (obs_count !== CNT_W'(4)) begin n_fail++; $display("FAIL full_count got %0d exp 4", obs_count); end
            end
            if (k < 4) cycle(1'b1, 1'b0, 32'h100, 32'd0, 3'b010, acc);
        end
        idle(6);
    endtask

    task automatic test_load_stall_byte();
        int st;
        idle(6);
        issue(1'b1, 32'h20, 32'h11223344, 3'b010, st);
        issue(1'b0, 32'h22, 32'd0, 3'b000, st);
        n_tests++;
        if (st < 1) begin n_fail++; $display("FAIL lb_stall got %0d stalls exp >=1", st); end
        idle(1);
        n_tests++;
        if (obs_lv !== 1'b1 || obs_ld !== 32'h00000022) begin
            n_fail++; $display("FAIL lb_data got v=%0b %h exp 1 00000022", obs_lv, obs_ld);
        end
    endtask

    task automatic test_cross_word();
        int st;
        logic [31:0] e;
        idle(6);
        issue(1'b1, 32'h43, 32'h0000BEEF, 3'b001, st);
        issue(1'b0, 32'h44, 32'd0, 3'b010, st);
        e = arch_word(32'h44);
        n_tests++;
        if (st < 1) begin n_fail++; $display("FAIL xword_stall got %0d stalls exp >=1", st); end
        idle(1);
        n_tests++;
        if (obs_ld !== e || obs_ld[7:0] !== 8'hBE) begin
            n_fail++; $display("FAIL xword_data got %h exp %h (byte0 be)", obs_ld, e);
        end
    endtask

    task automatic test_back_to_back();
        int st;
        idle(6);
        issue(1'b1, 32'h300, 32'hA5A55A5A, 3'b010, st);
        issue(1'b0, 32'h100, 32'd0, 3'b010, st);
        n_tests++;
        if (st != 0) begin n_fail++; $display("FAIL b2b_load_stall got %0d exp 0", st); end
        idle(1);
        n_tests++;
        if (obs_rw !== 1'b0 || obs_lv !== 1'b1) begin
            n_fail++; $display("FAIL b2b_n1 got rw=%0b lv=%0b exp rw=0 lv=1", obs_rw, obs_lv);
        end
        idle(1);
        n_tests++;
        if (obs_rw !== 1'b1 || obs_addr !== 32'h300) begin
            n_fail++; $display("FAIL b2b_n2 got rw=%0b %h exp rw=1 00000300", obs_rw, obs_addr);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_drain();
        bit acc;
        idle(6);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 32'h340 + 32'(k * 4), $urandom, 3'b010, acc);
            if (k < 3) cycle(1'b1, 1'b0, 32'h100, 32'd0, 3'b010, acc);
        end
        idle(1);
        n_tests++;
        if (mem_rw !== 1'b1 || sb_count !== CNT_W'(3)) begin
            n_fail++; $display("FAIL middrain_pre got rw=%0b cnt=%0d exp rw=1 cnt=3", mem_rw, sb_count);
        end
        do_reset();
        idle(4);
        n_tests++;
        if (obs_count !== '0) begin n_fail++; $display("FAIL middrain_post got %0d exp 0", obs_count); end
    endtask

`ifdef SB_FWD_EN
    task automatic test_forward();
        int st;
        idle(6);
        issue(1'b1, 32'h30, 32'hCAFEF00D, 3'b010, st);
        issue(1'b0, 32'h30, 32'd0, 3'b010, st);
        n_tests++;
        if (st != 0 || obs_rw !== 1'b0) begin n_fail++; $display("FAIL fwd_accept got stalls=%0d rw=%0b exp 0 0", st, obs_rw); end
        idle(1);
        n_tests++;
        if (obs_lv !== 1'b1 || obs_ld !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL fwd_data got v=%0b %h exp 1 cafef00d", obs_lv, obs_ld);
        end
        idle(6);
    endtask
`endif

    task automatic test_random();
        bit          acc, v, we;
        logic [2:0]  f;
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            we = 1'($urandom_range(0, 1));
            f  = pick_f3(int'($urandom_range(0, 4)));
            if (f == 3'b010) a = 32'($urandom_range(0, 11)) * 32'd4;
            else             a = 32'($urandom_range(0, 47));
            cycle(v, we, a, $urandom, f, acc);
            if (n % 50 == 49) idle(6);
        end
        idle(6);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = 3'b010;
        n_tests = 0; n_fail = 0;
        prev_load = 1'b0; prev_val = '0;
        for (int i = 0; i < 1024; i++) begin
            phys[i] = 8'($urandom);
            arch[i] = phys[i];
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single_store();
        test_full();
        test_load_stall_byte();
        test_cross_word();
        test_back_to_back();
        test_reset_mid_drain();
`ifdef SB_FWD_EN
        test_forward();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
